// File: rtl/bus_memory_target.sv
// Word-addressed memory target for the request/ready system bus.
// Accepts one transaction at a time, holds it for LATENCY edges, then
// completes it. Accesses outside the address window are completed with a
// sticky fault, so an initiator is never left waiting.
module bus_memory_target #(
    parameter int unsigned WORDS   = 1024,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_fault,
    output logic [15:0] o_access_count
);

    localparam int unsigned IDX_W     = $clog2(WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(WORDS * 4);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic               ready_d;
    logic               accept_c;
    logic               access_c;

    logic               rw_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;

    logic [31:0]        off_c;
    logic               in_win_c;
    logic [IDX_W-1:0]   index_c;
    logic               wr_en_c;

    logic [31:0]        mem [WORDS];

    // Window decode: the full 32-bit offset is compared so addresses below
    // BASE wrap to huge offsets and fall outside the window.
    assign off_c    = addr_q - BASE;
    assign in_win_c = (off_c < WIN_BYTES);
    assign index_c  = off_c[IDX_W+1:2];
    assign wr_en_c  = access_c & rw_q & in_win_c;

    // State register and completion outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            o_ready        <= 1'b0;
            o_rdata        <= 32'h0000_0000;
            o_fault        <= 1'b0;
            o_access_count <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_ready <= ready_d;
            if (access_c) begin
                o_access_count <= o_access_count + 16'd1;
                if (!in_win_c) begin
                    o_fault <= 1'b1;
                end
                if (!rw_q) begin
                    o_rdata <= in_win_c ? mem[index_c] : 32'h0000_0000;
                end
            end
        end
    end

    // Next-state, countdown and ready control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = o_ready;
        accept_c = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_request && !o_ready) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access_c = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!i_request) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Transaction capture at accept.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rw_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
        end else if (accept_c) begin
            rw_q    <= i_rw;
            addr_q  <= i_address;
            wdata_q <= i_wdata;
        end
    end

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge i_clock) begin
        if (wr_en_c) begin
            mem[index_c] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_bus_memory_target.sv
// Directed bench for bus_memory_target: one instance at LATENCY=2 and a
// small one at LATENCY=1 for the withdrawn-request case.
module tb_bus_memory_target;

    localparam logic [31:0] BASE0 = 32'h0001_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1;
    logic        fault0, fault1;
    logic [15:0] count0, count1;

    int n_asserts = 0;
    int n_fail    = 0;

    bus_memory_target #(.WORDS(1024), .BASE(BASE0), .LATENCY(2)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_request(req0), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata0),
        .o_ready(ready0), .o_fault(fault0), .o_access_count(count0)
    );

    bus_memory_target #(.WORDS(16), .BASE(BASE1), .LATENCY(1)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_request(req1), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata1),
        .o_ready(ready1), .o_fault(fault1), .o_access_count(count1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic sel_ready(input bit sel);
        return sel ? ready1 : ready0;
    endfunction

    // One full transaction: raise request, wait for ready, drop request,
    // confirm ready falls on the next edge. lat = edges after the accept edge.
    task automatic xact(input bit sel, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        bit got = 1'b0;
        @(negedge clk);
        rw = wr; addr = a; wdata = d;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sel_ready(sel)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_val("ready_timeout", 32'(got), 32'd1);
        rd = sel ? rdata1 : rdata0;
        @(negedge clk);
        if (sel) req1 = 1'b0; else req0 = 1'b0;
        @(posedge clk); #1;
        check_val("release", 32'(sel_ready(sel)), 32'd0);
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        // Reset values
        #2;
        check_val("rst_ready", 32'(ready0), 32'd0);
        check_val("rst_fault", 32'(fault0), 32'd0);
        check_val("rst_count", 32'(count0), 32'd0);
        check_val("rst_rdata", rdata0, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // DMA-style burst of four writes
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, 1'b1, BASE0 + 32'h10 + 32'(4 * i), 32'(i + 1), rd, lat);
        end
        check_val("burst_count", 32'(count0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, 1'b0, BASE0 + 32'h10 + 32'(4 * i), 32'h0, rd, lat);
            check_val("burst_rd", rd, 32'(i + 1));
        end

        // Write then read back with latency check
        xact(1'b0, 1'b1, BASE0 + 32'h8, 32'h1234_5678, rd, lat);
        check_val("wr_latency", 32'(lat), 32'd2);
        xact(1'b0, 1'b0, BASE0 + 32'h8, 32'h0, rd, lat);
        check_val("rd_latency", 32'(lat), 32'd2);
        check_val("rd_data", rd, 32'h1234_5678);

        // Unaligned address maps to the containing word
        xact(1'b0, 1'b1, BASE0 + 32'h6, 32'hA5A5_A5A5, rd, lat);
        xact(1'b0, 1'b0, BASE0 + 32'h4, 32'h0, rd, lat);
        check_val("unaligned", rd, 32'hA5A5_A5A5);

        // Out-of-window accesses
        xact(1'b0, 1'b1, BASE0, 32'h5555_0000, rd, lat);
        check_val("fault_before", 32'(fault0), 32'd0);
        xact(1'b0, 1'b0, BASE0 + 32'h1000, 32'h0, rd, lat);
        check_val("oow_rdata", rd, 32'd0);
        check_val("oow_fault", 32'(fault0), 32'd1);
        xact(1'b0, 1'b1, BASE0 + 32'h1000, 32'hDEAD_BEEF, rd, lat);
        xact(1'b0, 1'b0, BASE0, 32'h0, rd, lat);
        check_val("oow_wr_discard", rd, 32'h5555_0000);

        // Reset during BUSY of a write
        xact(1'b0, 1'b1, BASE0 + 32'h20, 32'h1111_2222, rd, lat);
        @(negedge clk);
        rw = 1'b1; addr = BASE0 + 32'h20; wdata = 32'h9999_9999; req0 = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ready", 32'(ready0), 32'd0);
        check_val("midrst_fault", 32'(fault0), 32'd0);
        check_val("midrst_count", 32'(count0), 32'd0);
        @(negedge clk); req0 = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        xact(1'b0, 1'b0, BASE0 + 32'h20, 32'h0, rd, lat);
        check_val("midrst_mem", rd, 32'h1111_2222);
        check_val("midrst_fault_clr", 32'(fault0), 32'd0);

        // BASE-4 wraps to a large offset and is rejected
        xact(1'b0, 1'b0, BASE0 - 32'h4, 32'h0, rd, lat);
        check_val("below_base_rdata", rd, 32'd0);
        check_val("below_base_fault", 32'(fault0), 32'd1);
        check_val("count_after_rst", 32'(count0), 32'd2);

        // LATENCY=1, request withdrawn in BUSY
        @(negedge clk);
        rw = 1'b1; addr = BASE1; wdata = 32'h0000_0077; req1 = 1'b1;
        @(posedge clk); #1;
        check_val("l1_accept_rdy", 32'(ready1), 32'd0);
        @(negedge clk); req1 = 1'b0;
        @(posedge clk); #1;
        check_val("l1_pulse_hi", 32'(ready1), 32'd1);
        @(posedge clk); #1;
        check_val("l1_pulse_lo", 32'(ready1), 32'd0);
        @(posedge clk); #1;
        check_val("l1_stay_idle", 32'(ready1), 32'd0);
        xact(1'b1, 1'b0, BASE1, 32'h0, rd, lat);
        check_val("l1_latency", 32'(lat), 32'd1);
        check_val("l1_rdata", rd, 32'h0000_0077);
        check_val("l1_count", 32'(count1), 32'd2);
        check_val("l1_fault", 32'(fault1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
